// File: rtl/axi_port_arbiter.sv
// rtl/axi_port_arbiter.sv - two-requester burst arbiter in front of a 32-bit RAM slave
//
// Purpose: grants one of two requesters (M0, M1) a single read or write burst
// to a shared downstream slave, round-robin on ties, then passes that burst's
// data beats straight through until the beat count is exhausted.
//
// Ports:
//   ARES_design_CLK, ARES_design_RESET_N   clock, synchronous active-low reset
//   M{0,1}_Req_*                           per-requester command (valid/ready/write/addr/size)
//   M{0,1}_W_*, M{0,1}_R_*                 per-requester write and read beat channels
//   S_WReq_*, S_RReq_*                     downstream write / read command
//   S_W_*, S_R_*                           downstream write / read beats
//   grant, busy                            one-hot owner and not-idle status
module axi_port_arbiter (
    input  logic        ARES_design_CLK,
    input  logic        ARES_design_RESET_N,

    input  logic        M0_Req_valid,
    output logic        M0_Req_ready,
    input  logic        M0_Req_write,
    input  logic [31:0] M0_Req_addr,
    input  logic [31:0] M0_Req_size,
    input  logic [31:0] M0_W_data,
    input  logic        M0_W_valid,
    output logic        M0_W_ready,
    output logic [31:0] M0_R_data,
    output logic        M0_R_valid,
    input  logic        M0_R_ready,

    input  logic        M1_Req_valid,
    output logic        M1_Req_ready,
    input  logic        M1_Req_write,
    input  logic [31:0] M1_Req_addr,
    input  logic [31:0] M1_Req_size,
    input  logic [31:0] M1_W_data,
    input  logic        M1_W_valid,
    output logic        M1_W_ready,
    output logic [31:0] M1_R_data,
    output logic        M1_R_valid,
    input  logic        M1_R_ready,

    output logic [31:0] S_WReq_addr,
    output logic [31:0] S_WReq_size,
    output logic        S_WReq_valid,
    input  logic        S_WReq_ready,
    output logic [31:0] S_W_data,
    output logic        S_W_valid,
    input  logic        S_W_ready,

    output logic [31:0] S_RReq_addr,
    output logic [31:0] S_RReq_size,
    output logic        S_RReq_valid,
    input  logic        S_RReq_ready,
    input  logic [31:0] S_R_data,
    input  logic        S_R_valid,
    output logic        S_R_ready,

    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;

    state_t      state, state_next;
    logic [31:0] remaining;
    logic        owner;
    logic        last_grant;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_size;

    logic        winner;
    logic        accept;
    logic        req_done;
    logic        beat;
    logic        wr_phase;
    logic        rd_phase;

    // On a tie the requester that did not win last time goes next.
    assign winner = (M0_Req_valid & M1_Req_valid) ? ~last_grant : M1_Req_valid;
    assign accept = (state == ST_IDLE) & (M0_Req_valid | M1_Req_valid);

    assign M0_Req_ready = accept & ~winner;
    assign M1_Req_ready = accept & winner;

    assign req_done = (state == ST_REQ) & (cmd_write ? S_WReq_ready : S_RReq_ready);
    assign wr_phase = (state == ST_DATA) & cmd_write;
    assign rd_phase = (state == ST_DATA) & ~cmd_write;

    assign grant = (state == ST_IDLE) ? 2'b00 : {owner, ~owner};
    assign busy  = (state != ST_IDLE);

    // Command presentation: addr/size only shown alongside the matching valid.
    always_comb begin
        S_WReq_valid = 1'b0;
        S_WReq_addr  = '0;
        S_WReq_size  = '0;
        S_RReq_valid = 1'b0;
        S_RReq_addr  = '0;
        S_RReq_size  = '0;
        if (state == ST_REQ) begin
            if (cmd_write) begin
                S_WReq_valid = 1'b1;
                S_WReq_addr  = cmd_addr;
                S_WReq_size  = cmd_size;
            end else begin
                S_RReq_valid = 1'b1;
                S_RReq_addr  = cmd_addr;
                S_RReq_size  = cmd_size;
            end
        end
    end

    // Beat pass-through for the owner only; everyone else sees zeros.
    always_comb begin
        S_W_data   = '0;
        S_W_valid  = 1'b0;
        S_R_ready  = 1'b0;
        M0_W_ready = 1'b0;
        M1_W_ready = 1'b0;
        M0_R_data  = '0;
        M0_R_valid = 1'b0;
        M1_R_data  = '0;
        M1_R_valid = 1'b0;
        if (wr_phase) begin
            S_W_data  = owner ? M1_W_data  : M0_W_data;
            S_W_valid = owner ? M1_W_valid : M0_W_valid;
            if (owner) M1_W_ready = S_W_ready;
            else       M0_W_ready = S_W_ready;
        end
        if (rd_phase) begin
            S_R_ready = owner ? M1_R_ready : M0_R_ready;
            if (owner) begin
                M1_R_data  = S_R_data;
                M1_R_valid = S_R_valid;
            end else begin
                M0_R_data  = S_R_data;
                M0_R_valid = S_R_valid;
            end
        end
    end

    assign beat = wr_phase ? (S_W_valid & S_W_ready) : (rd_phase & S_R_valid & S_R_ready);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ:  if (req_done) state_next = (cmd_size == 32'd0) ? ST_IDLE : ST_DATA;
            ST_DATA: if (beat && remaining == 32'd1) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ARES_design_CLK) begin
        if (!ARES_design_RESET_N) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_size   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= winner;
                last_grant <= winner;
                cmd_write  <= winner ? M1_Req_write : M0_Req_write;
                cmd_addr   <= winner ? M1_Req_addr  : M0_Req_addr;
                cmd_size   <= winner ? M1_Req_size  : M0_Req_size;
            end
            if (req_done) remaining <= cmd_size;
            else if (beat) remaining <= remaining - 32'd1;
        end
    end

endmodule

// File: tb/tb_axi_port_arbiter.sv
// tb/tb_axi_port_arbiter.sv - directed self-checking bench for axi_port_arbiter
module tb_axi_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_write;
    logic [31:0] m0_req_addr, m0_req_size, m0_w_data, m0_r_data;
    logic        m0_w_valid, m0_w_ready, m0_r_valid, m0_r_ready;
    logic        m1_req_valid, m1_req_ready, m1_req_write;
    logic [31:0] m1_req_addr, m1_req_size, m1_w_data, m1_r_data;
    logic        m1_w_valid, m1_w_ready, m1_r_valid, m1_r_ready;
    logic [31:0] s_wreq_addr, s_wreq_size, s_w_data, s_rreq_addr, s_rreq_size, s_r_data;
    logic        s_wreq_valid, s_wreq_ready, s_w_valid, s_w_ready;
    logic        s_rreq_valid, s_rreq_ready, s_r_valid, s_r_ready;
    logic [1:0]  grant;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axi_port_arbiter dut (
        .ARES_design_CLK(clk), .ARES_design_RESET_N(rst_n),
        .M0_Req_valid(m0_req_valid), .M0_Req_ready(m0_req_ready), .M0_Req_write(m0_req_write),
        .M0_Req_addr(m0_req_addr), .M0_Req_size(m0_req_size),
        .M0_W_data(m0_w_data), .M0_W_valid(m0_w_valid), .M0_W_ready(m0_w_ready),
        .M0_R_data(m0_r_data), .M0_R_valid(m0_r_valid), .M0_R_ready(m0_r_ready),
        .M1_Req_valid(m1_req_valid), .M1_Req_ready(m1_req_ready), .M1_Req_write(m1_req_write),
        .M1_Req_addr(m1_req_addr), .M1_Req_size(m1_req_size),
        .M1_W_data(m1_w_data), .M1_W_valid(m1_w_valid), .M1_W_ready(m1_w_ready),
        .M1_R_data(m1_r_data), .M1_R_valid(m1_r_valid), .M1_R_ready(m1_r_ready),
        .S_WReq_addr(s_wreq_addr), .S_WReq_size(s_wreq_size), .S_WReq_valid(s_wreq_valid),
        .S_WReq_ready(s_wreq_ready),
        .S_W_data(s_w_data), .S_W_valid(s_w_valid), .S_W_ready(s_w_ready),
        .S_RReq_addr(s_rreq_addr), .S_RReq_size(s_rreq_size), .S_RReq_valid(s_rreq_valid),
        .S_RReq_ready(s_rreq_ready),
        .S_R_data(s_r_data), .S_R_valid(s_r_valid), .S_R_ready(s_r_ready),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req_valid = 0; m0_req_write = 0; m0_req_addr = 0; m0_req_size = 0;
        m0_w_data = 0; m0_w_valid = 0; m0_r_ready = 0;
        m1_req_valid = 0; m1_req_write = 0; m1_req_addr = 0; m1_req_size = 0;
        m1_w_data = 0; m1_w_valid = 0; m1_r_ready = 0;
        s_wreq_ready = 0; s_w_ready = 0; s_rreq_ready = 0; s_r_data = 0; s_r_valid = 0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_wreq_valid", 32'(s_wreq_valid), 0);
        chk("rst_rreq_valid", 32'(s_rreq_valid), 0);
        chk("rst_m0_req_ready", 32'(m0_req_ready), 0);

        // Tie after reset: M0 (write 3/4) wins, M1 (read 0/2) waits.
        m0_req_valid = 1; m0_req_write = 1; m0_req_addr = 3; m0_req_size = 4;
        m1_req_valid = 1; m1_req_write = 0; m1_req_addr = 0; m1_req_size = 2;
        settle();
        chk("tie1_m0_ready", 32'(m0_req_ready), 1);
        chk("tie1_m1_ready", 32'(m1_req_ready), 0);
        tick();
        m0_req_valid = 0;
        s_wreq_ready = 1;
        settle();
        chk("wr_grant", 32'(grant), 32'h1);
        chk("wr_busy", 32'(busy), 1);
        chk("wr_wreq_valid", 32'(s_wreq_valid), 1);
        chk("wr_wreq_addr", s_wreq_addr, 3);
        chk("wr_wreq_size", s_wreq_size, 4);
        chk("wr_m1_ready_in_req", 32'(m1_req_ready), 0);
        tick();
        settle();
        chk("wr_wreq_valid_1cyc", 32'(s_wreq_valid), 0);
        s_w_ready = 1; m0_w_valid = 1;
        for (int i = 0; i < 4; i++) begin
            m0_w_data = 32'hA + 32'(i);
            settle();
            chk("wr_beat_data", s_w_data, 32'hA + 32'(i));
            chk("wr_beat_valid", 32'(s_w_valid), 1);
            chk("wr_m0_w_ready", 32'(m0_w_ready), 1);
            chk("wr_m1_w_ready", 32'(m1_w_ready), 0);
            chk("wr_busy_during", 32'(busy), 1);
            tick();
        end
        m0_w_valid = 0;
        // Burst done; M1 still asking and M0 re-asks: tie goes to M1.
        m0_req_valid = 1; m0_req_write = 0; m0_req_addr = 7; m0_req_size = 0;
        settle();
        chk("wr_busy_after", 32'(busy), 0);
        chk("wr_s_w_valid_after", 32'(s_w_valid), 0);
        chk("tie2_m1_ready", 32'(m1_req_ready), 1);
        chk("tie2_m0_ready", 32'(m0_req_ready), 0);
        tick();
        m1_req_valid = 0;
        s_rreq_ready = 1;
        settle();
        chk("rd_grant", 32'(grant), 32'h2);
        chk("rd_rreq_valid", 32'(s_rreq_valid), 1);
        chk("rd_rreq_addr", s_rreq_addr, 0);
        chk("rd_rreq_size", s_rreq_size, 2);
        chk("rd_wreq_valid", 32'(s_wreq_valid), 0);
        chk("rd_m0_ready_in_req", 32'(m0_req_ready), 0);
        tick();
        // Read beats with M1_R_ready toggling 1,0,1.
        s_r_valid = 1; s_r_data = 32'h11; m1_r_ready = 1;
        settle();
        chk("rd_b1_valid", 32'(m1_r_valid), 1);
        chk("rd_b1_data", m1_r_data, 32'h11);
        chk("rd_b1_s_r_ready", 32'(s_r_ready), 1);
        chk("rd_m0_r_valid", 32'(m0_r_valid), 0);
        chk("rd_m0_r_data", m0_r_data, 0);
        tick();
        s_r_data = 32'h22; m1_r_ready = 0;
        settle();
        chk("rd_stall_s_r_ready", 32'(s_r_ready), 0);
        chk("rd_stall_busy", 32'(busy), 1);
        tick();
        m1_r_ready = 1;
        settle();
        chk("rd_b2_s_r_ready", 32'(s_r_ready), 1);
        chk("rd_b2_data", m1_r_data, 32'h22);
        tick();
        s_r_valid = 0; m1_r_ready = 0;
        settle();
        chk("rd_busy_after", 32'(busy), 0);
        chk("rd_m1_r_valid_after", 32'(m1_r_valid), 0);
        chk("sz0_m0_ready", 32'(m0_req_ready), 1);

        // Size-0 read by M0: one REQ handshake, straight back to IDLE.
        tick();
        m0_req_valid = 0;
        settle();
        chk("sz0_rreq_valid", 32'(s_rreq_valid), 1);
        chk("sz0_rreq_size", s_rreq_size, 0);
        chk("sz0_rreq_addr", s_rreq_addr, 7);
        tick();
        settle();
        chk("sz0_busy_after", 32'(busy), 0);
        chk("sz0_grant_after", 32'(grant), 0);

        // Stalled write command from M1 (tie, last was M0 so M1 wins).
        s_wreq_ready = 0;
        m1_req_valid = 1; m1_req_write = 1; m1_req_addr = 9; m1_req_size = 1;
        m0_req_valid = 1; m0_req_write = 1; m0_req_addr = 0; m0_req_size = 4;
        settle();
        chk("tie3_m1_ready", 32'(m1_req_ready), 1);
        chk("tie3_m0_ready", 32'(m0_req_ready), 0);
        tick();
        m1_req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_wreq_valid", 32'(s_wreq_valid), 1);
            chk("stall_wreq_addr", s_wreq_addr, 9);
            chk("stall_wreq_size", s_wreq_size, 1);
            chk("stall_m0_ready", 32'(m0_req_ready), 0);
            chk("stall_m1_ready", 32'(m1_req_ready), 0);
            tick();
        end
        s_wreq_ready = 1;
        tick();
        m1_w_valid = 1; m1_w_data = 32'h55;
        settle();
        chk("stall_beat_data", s_w_data, 32'h55);
        chk("stall_m1_w_ready", 32'(m1_w_ready), 1);
        chk("stall_m0_w_ready", 32'(m0_w_ready), 0);
        tick();
        m1_w_valid = 0;
        settle();
        chk("stall_busy_after", 32'(busy), 0);
        chk("mb_m0_ready", 32'(m0_req_ready), 1);

        // Reset after beat 1 of a 4-beat M0 write.
        tick();
        m0_req_valid = 0;
        tick();
        m0_w_valid = 1; m0_w_data = 32'h1;
        settle();
        chk("mb_beat1_valid", 32'(s_w_valid), 1);
        tick();
        rst_n = 0;
        m0_w_data = 32'h2;
        tick();
        rst_n = 1;
        settle();
        chk("mb_busy", 32'(busy), 0);
        chk("mb_s_w_valid", 32'(s_w_valid), 0);
        chk("mb_m0_w_ready", 32'(m0_w_ready), 0);
        chk("mb_grant", 32'(grant), 0);
        m0_w_valid = 0;
        m0_req_valid = 1; m1_req_valid = 1;
        settle();
        chk("mb_tie_m0_ready", 32'(m0_req_ready), 1);
        chk("mb_tie_m1_ready", 32'(m1_req_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
